// File: rtl/sequenced_decoder_if.sv
// Decoder-side bundle: instruction handshake, field/strobe outputs to regfile/ALU/PC,
// and the data-memory request/ack pair. slave = decoder, master = its environment.
interface sequenced_decoder_if #(
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int ParamBits         = 8,
  parameter int DataWidth         = 8,
  parameter int NumStatusBits     = 3
);
  logic                         instr_valid;
  logic                         instr_ready;
  logic [PROGRAM_DataWidth-1:0] instruction;
  logic [NumStatusBits-1:0]     status;
  logic [NumOpCodeBits-1:0]     opcode;
  logic [ParamBits-1:0]         param;
  logic [DataWidth-1:0]         literal_adr;
  logic [SEL_WIDTH-1:0]         rd_sel1;
  logic [SEL_WIDTH-1:0]         rd_sel2;
  logic                         rd_en1;
  logic                         rd_en2;
  logic                         wr_en;
  logic [SEL_WIDTH-1:0]         wr_sel;
  logic                         sel_reg_in_alu_decoder;
  logic                         sel_reg_in_mem;
  logic                         cnt_wr_en;
  logic                         mem_req;
  logic                         mem_we;
  logic                         mem_adr_src;
  logic                         mem_ack;
  logic                         mem_err;
  logic                         illegal_op;
  logic                         busy;

  modport slave (
    input  instr_valid, instruction, status, mem_ack,
    output instr_ready, opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
           wr_en, wr_sel, sel_reg_in_alu_decoder, sel_reg_in_mem, cnt_wr_en,
           mem_req, mem_we, mem_adr_src, mem_err, illegal_op, busy
  );

  modport master (
    output instr_valid, instruction, status, mem_ack,
    input  instr_ready, opcode, param, literal_adr, rd_sel1, rd_sel2, rd_en1, rd_en2,
           wr_en, wr_sel, sel_reg_in_alu_decoder, sel_reg_in_mem, cnt_wr_en,
           mem_req, mem_we, mem_adr_src, mem_err, illegal_op, busy
  );
endinterface

// File: rtl/sequenced_decoder.sv
// Multi-cycle instruction decoder: IDLE -> EXEC (-> MEM (-> WB)) with registered strobes,
// load/store over a req/ack memory port with timeout, and reserved-opcode flagging.
module sequenced_decoder #(
  parameter int PROGRAM_DataWidth = 16,
  parameter int NumOpCodeBits     = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int OP1_BIT_POS       = 9,
  parameter int OP2_BIT_POS       = 4,
  parameter int ParamBits         = 8,
  parameter int DataWidth         = 8,
  parameter int NumStatusBits     = 3,
  parameter int MEM_TIMEOUT       = 15
) (
  input logic                 clk,
  input logic                 reset_n,
  sequenced_decoder_if.slave  bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  // Opcode map: 0 NOP, 1-5 ADD SUB AND OR XOR, 6-8 NOT SHL SHR, 9 VAL,
  // 16 GOTO, 17-21 IFZ IFNZ IFEQ IFST IFGT, 24-27 LD ST LDI STI, the rest reserved.
  localparam logic [NumOpCodeBits-1:0] OP_NOP  = NumOpCodeBits'(0);
  localparam logic [NumOpCodeBits-1:0] OP_ADD  = NumOpCodeBits'(1);
  localparam logic [NumOpCodeBits-1:0] OP_SUB  = NumOpCodeBits'(2);
  localparam logic [NumOpCodeBits-1:0] OP_AND  = NumOpCodeBits'(3);
  localparam logic [NumOpCodeBits-1:0] OP_OR   = NumOpCodeBits'(4);
  localparam logic [NumOpCodeBits-1:0] OP_XOR  = NumOpCodeBits'(5);
  localparam logic [NumOpCodeBits-1:0] OP_NOT  = NumOpCodeBits'(6);
  localparam logic [NumOpCodeBits-1:0] OP_SHL  = NumOpCodeBits'(7);
  localparam logic [NumOpCodeBits-1:0] OP_SHR  = NumOpCodeBits'(8);
  localparam logic [NumOpCodeBits-1:0] OP_VAL  = NumOpCodeBits'(9);
  localparam logic [NumOpCodeBits-1:0] OP_GOTO = NumOpCodeBits'(16);
  localparam logic [NumOpCodeBits-1:0] OP_IFZ  = NumOpCodeBits'(17);
  localparam logic [NumOpCodeBits-1:0] OP_IFNZ = NumOpCodeBits'(18);
  localparam logic [NumOpCodeBits-1:0] OP_IFEQ = NumOpCodeBits'(19);
  localparam logic [NumOpCodeBits-1:0] OP_IFST = NumOpCodeBits'(20);
  localparam logic [NumOpCodeBits-1:0] OP_IFGT = NumOpCodeBits'(21);
  localparam logic [NumOpCodeBits-1:0] OP_LD   = NumOpCodeBits'(24);
  localparam logic [NumOpCodeBits-1:0] OP_ST   = NumOpCodeBits'(25);
  localparam logic [NumOpCodeBits-1:0] OP_LDI  = NumOpCodeBits'(26);
  localparam logic [NumOpCodeBits-1:0] OP_STI  = NumOpCodeBits'(27);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {BR_NONE, BR_ALWAYS, BR_Z, BR_NZ, BR_EQ, BR_ST, BR_GT} branch_t;

  state_t                   state_reg;
  branch_t                  branch_reg;
  logic [CNT_W-1:0]         wait_cnt_reg;
  logic                     is_mem_reg;
  logic                     is_store_reg;
  logic                     is_indirect_reg;
  logic                     branch_taken;
  logic [NumStatusBits-1:0] status_in;

  logic [NumOpCodeBits-1:0]       in_op;
  logic [ParamBits-1:0]           in_param;
  logic [DataWidth+ParamBits-1:0] param_wide;

  assign in_op      = bus.instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
  assign in_param   = bus.instruction[ParamBits-1:0];
  assign param_wide = {{DataWidth{1'b0}}, in_param};
  assign status_in  = bus.status;

  // Branch condition depends on live ALU flags during EXEC, so this strobe is decoded here.
  always_comb begin
    branch_taken = 1'b0;
    case (branch_reg)
      BR_ALWAYS: branch_taken = 1'b1;
      BR_Z:      branch_taken = status_in[0];
      BR_NZ:     branch_taken = ~status_in[0];
      BR_EQ:     branch_taken = status_in[1];
      BR_ST:     branch_taken = status_in[2];
      BR_GT:     branch_taken = ~status_in[1] & ~status_in[2];
      default:   branch_taken = 1'b0;
    endcase
  end

  assign bus.cnt_wr_en = (state_reg == EXEC) && branch_taken;
  assign bus.busy      = ~bus.instr_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg                  <= IDLE;
      branch_reg                 <= BR_NONE;
      wait_cnt_reg               <= '0;
      is_mem_reg                 <= 1'b0;
      is_store_reg               <= 1'b0;
      is_indirect_reg            <= 1'b0;
      bus.instr_ready            <= 1'b1;
      bus.opcode                 <= '0;
      bus.param                  <= '0;
      bus.literal_adr            <= '0;
      bus.rd_sel1                <= '0;
      bus.rd_sel2                <= '0;
      bus.wr_sel                 <= '0;
      bus.rd_en1                 <= 1'b0;
      bus.rd_en2                 <= 1'b0;
      bus.wr_en                  <= 1'b0;
      bus.sel_reg_in_alu_decoder <= 1'b0;
      bus.sel_reg_in_mem         <= 1'b0;
      bus.mem_req                <= 1'b0;
      bus.mem_we                 <= 1'b0;
      bus.mem_adr_src            <= 1'b0;
      bus.mem_err                <= 1'b0;
      bus.illegal_op             <= 1'b0;
    end else begin
      // Strobes live for exactly the state that raises them.
      bus.rd_en1                 <= 1'b0;
      bus.rd_en2                 <= 1'b0;
      bus.wr_en                  <= 1'b0;
      bus.sel_reg_in_alu_decoder <= 1'b0;
      bus.sel_reg_in_mem         <= 1'b0;
      bus.mem_req                <= 1'b0;
      bus.mem_we                 <= 1'b0;
      bus.mem_adr_src            <= 1'b0;
      bus.mem_err                <= 1'b0;
      bus.illegal_op             <= 1'b0;
      branch_reg                 <= BR_NONE;
      case (state_reg)
        IDLE: begin
          if (bus.instr_valid) begin
            state_reg       <= EXEC;
            bus.instr_ready <= 1'b0;
            bus.opcode      <= in_op;
            bus.param       <= in_param;
            bus.literal_adr <= param_wide[DataWidth-1:0];
            bus.rd_sel1     <= bus.instruction[OP1_BIT_POS -: SEL_WIDTH];
            bus.wr_sel      <= bus.instruction[OP1_BIT_POS -: SEL_WIDTH];
            bus.rd_sel2     <= bus.instruction[OP2_BIT_POS -: SEL_WIDTH];
            is_mem_reg      <= (in_op == OP_LD) || (in_op == OP_ST) ||
                               (in_op == OP_LDI) || (in_op == OP_STI);
            is_store_reg    <= (in_op == OP_ST) || (in_op == OP_STI);
            is_indirect_reg <= (in_op == OP_LDI) || (in_op == OP_STI);
            case (in_op)
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                bus.rd_en1                 <= 1'b1;
                bus.rd_en2                 <= 1'b1;
                bus.wr_en                  <= 1'b1;
                bus.sel_reg_in_alu_decoder <= 1'b1;
              end
              OP_NOT, OP_SHL, OP_SHR: begin
                bus.rd_en1                 <= 1'b1;
                bus.wr_en                  <= 1'b1;
                bus.sel_reg_in_alu_decoder <= 1'b1;
              end
              OP_VAL:  bus.wr_en <= 1'b1;
              OP_GOTO: branch_reg <= BR_ALWAYS;
              OP_IFZ:  branch_reg <= BR_Z;
              OP_IFNZ: branch_reg <= BR_NZ;
              OP_IFEQ: branch_reg <= BR_EQ;
              OP_IFST: branch_reg <= BR_ST;
              OP_IFGT: branch_reg <= BR_GT;
              OP_NOP, OP_LD, OP_ST, OP_LDI, OP_STI: ;
              default: bus.illegal_op <= 1'b1;
            endcase
          end
        end
        EXEC: begin
          if (is_mem_reg) begin
            state_reg       <= MEM;
            wait_cnt_reg    <= '0;
            bus.mem_req     <= 1'b1;
            bus.mem_we      <= is_store_reg;
            bus.rd_en1      <= is_store_reg;
            bus.rd_en2      <= is_indirect_reg;
            bus.mem_adr_src <= is_indirect_reg;
          end else begin
            state_reg       <= IDLE;
            bus.instr_ready <= 1'b1;
          end
        end
        MEM: begin
          // An ack on the final allowed cycle still completes the access.
          if (bus.mem_ack) begin
            if (is_store_reg) begin
              state_reg       <= IDLE;
              bus.instr_ready <= 1'b1;
            end else begin
              state_reg          <= WB;
              bus.wr_en          <= 1'b1;
              bus.sel_reg_in_mem <= 1'b1;
            end
          end else if (wait_cnt_reg == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_reg       <= IDLE;
            bus.instr_ready <= 1'b1;
            bus.mem_err     <= 1'b1;
          end else begin
            wait_cnt_reg    <= wait_cnt_reg + CNT_W'(1);
            bus.mem_req     <= 1'b1;
            bus.mem_we      <= is_store_reg;
            bus.rd_en1      <= is_store_reg;
            bus.rd_en2      <= is_indirect_reg;
            bus.mem_adr_src <= is_indirect_reg;
          end
        end
        WB: begin
          state_reg       <= IDLE;
          bus.instr_ready <= 1'b1;
        end
        default: begin
          state_reg       <= IDLE;
          bus.instr_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sequenced_decoder.sv
// Random + directed bench: builds the expected per-cycle output vector from the opcode
// table and the planned ack/reset timing, and one negedge process compares every cycle.
module tb_sequenced_decoder;
  localparam int T = 15;

  localparam int K_NOP = 0, K_ALU2 = 1, K_ALU1 = 2, K_VAL = 3, K_BR = 4,
                 K_LD = 5, K_ST = 6, K_LDI = 7, K_STI = 8, K_RSV = 9;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [4:0] opcode;
    logic [7:0] param;
    logic [7:0] lit;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] ws;
    logic       rd1, rd2, wr, salu, smem, cnt, req, we, asrc, err, ill;
  } outs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sequenced_decoder_if bus ();
  sequenced_decoder #(.MEM_TIMEOUT(T)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int    checks   = 0;
  int    failures = 0;
  outs_t exp_cur;
  logic  exp_on = 1'b0;
  string phase  = "init";
  int    txn_no = 0;

  logic [4:0] last_op;
  logic [7:0] last_param;
  logic [1:0] last_rs1, last_rs2;
  logic       pending_err;

  function automatic int kind(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 0) return K_NOP;
    if (v >= 1 && v <= 5) return K_ALU2;
    if (v >= 6 && v <= 8) return K_ALU1;
    if (v == 9) return K_VAL;
    if (v >= 16 && v <= 21) return K_BR;
    if (v == 24) return K_LD;
    if (v == 25) return K_ST;
    if (v == 26) return K_LDI;
    if (v == 27) return K_STI;
    return K_RSV;
  endfunction

  function automatic logic taken(input logic [4:0] op, input logic [2:0] s);
    case (int'(op))
      16: return 1'b1;
      17: return s[0];
      18: return !s[0];
      19: return s[1];
      20: return s[2];
      21: return !s[1] && !s[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic outs_t base_exp(input logic rdy);
    outs_t e;
    e        = '0;
    e.ready  = rdy;
    e.busy   = !rdy;
    e.opcode = last_op;
    e.param  = last_param;
    e.lit    = last_param;
    e.rs1    = last_rs1;
    e.rs2    = last_rs2;
    e.ws     = last_rs1;
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t a;
    a.ready = bus.instr_ready;  a.busy = bus.busy;       a.opcode = bus.opcode;
    a.param = bus.param;        a.lit = bus.literal_adr; a.rs1 = bus.rd_sel1;
    a.rs2   = bus.rd_sel2;      a.ws = bus.wr_sel;       a.rd1 = bus.rd_en1;
    a.rd2   = bus.rd_en2;       a.wr = bus.wr_en;        a.salu = bus.sel_reg_in_alu_decoder;
    a.smem  = bus.sel_reg_in_mem; a.cnt = bus.cnt_wr_en; a.req = bus.mem_req;
    a.we    = bus.mem_we;       a.asrc = bus.mem_adr_src; a.err = bus.mem_err;
    a.ill   = bus.illegal_op;
    return a;
  endfunction

  always @(negedge clk) begin
    if (exp_on) begin
      outs_t a;
      a = sample();
      checks++;
      if (a !== exp_cur) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t txn=%0d phase=%s got=%h want=%h diff=%h",
                 $time, txn_no, phase, a, exp_cur, a ^ exp_cur);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [2:0] st,
                      input logic ack, input logic rn, input outs_t e, input string ph);
    @(posedge clk);
    #1;
    bus.instr_valid = v;
    bus.instruction = ins;
    bus.status      = st;
    bus.mem_ack     = ack;
    reset_n         = rn;
    exp_cur         = e;
    phase           = ph;
    exp_on          = 1'b1;
  endtask

  task automatic idle_step();
    step(1'b0, 16'($urandom), 3'($urandom), 1'($urandom), 1'b1, base_exp(1'b1) | {$bits(outs_t){1'b0}}, "idle");
    if (pending_err) exp_cur.err = 1'b1;
    pending_err = 1'b0;
  endtask

  // st_force < 0 means random status during EXEC; ack_at 0 means no ack at all.
  task automatic txn(input logic [4:0] op, input logic [1:0] op1, input logic [7:0] prm,
                     input int ack_at, input int gap, input int rst_at, input int st_force);
    outs_t       e;
    logic [15:0] ins;
    logic [2:0]  s;
    int          k;
    txn_no++;
    ins = {op, 1'($urandom), op1, prm};
    for (int g = 0; g < gap; g++) idle_step();
    e = base_exp(1'b1);
    e.err = pending_err;
    step(1'b1, ins, 3'($urandom), 1'($urandom), 1'b1, e, "accept");
    pending_err = 1'b0;
    last_op    = ins[15:11];
    last_rs1   = 2'((ins >> 8) & 16'd3);
    last_rs2   = 2'((ins >> 3) & 16'd3);
    last_param = 8'(ins & 16'hFF);
    k = kind(op);
    s = (st_force >= 0) ? 3'(st_force) : 3'($urandom);
    e = base_exp(1'b0);
    e.rd1  = (k == K_ALU2) || (k == K_ALU1);
    e.rd2  = (k == K_ALU2);
    e.wr   = (k == K_ALU2) || (k == K_ALU1) || (k == K_VAL);
    e.salu = (k == K_ALU2) || (k == K_ALU1);
    e.cnt  = (k == K_BR) && taken(op, s);
    e.ill  = (k == K_RSV);
    step(1'($urandom), 16'($urandom), s, 1'($urandom), 1'b1, e, "exec");
    if (k >= K_LD && k <= K_STI) begin
      for (int c = 1; c <= T; c++) begin
        e = base_exp(1'b0);
        e.req  = 1'b1;
        e.we   = (k == K_ST) || (k == K_STI);
        e.rd1  = e.we;
        e.rd2  = (k == K_LDI) || (k == K_STI);
        e.asrc = e.rd2;
        if (c == rst_at) begin
          step(1'($urandom), 16'($urandom), 3'($urandom), 1'b0, 1'b0, e, "mem_rst");
          last_op = '0; last_param = '0; last_rs1 = '0; last_rs2 = '0;
          pending_err = 1'b0;
          return;
        end
        step(1'($urandom), 16'($urandom), 3'($urandom), (c == ack_at), 1'b1, e, "mem");
        if (c == ack_at) break;
        if (c == T) pending_err = 1'b1;
      end
      if ((k == K_LD || k == K_LDI) && ack_at >= 1 && ack_at <= T) begin
        e = base_exp(1'b0);
        e.wr   = 1'b1;
        e.smem = 1'b1;
        step(1'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 1'b1, e, "wb");
      end
    end
  endtask

  task automatic settle_and_look();
    idle_step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] sv [4];
    sv[0] = 3'b000; sv[1] = 3'b001; sv[2] = 3'b010; sv[3] = 3'b100;
    last_op = '0; last_param = '0; last_rs1 = '0; last_rs2 = '0; pending_err = 1'b0;
    reset_n = 1'b0; bus.instr_valid = 1'b0; bus.instruction = '0;
    bus.status = '0; bus.mem_ack = 1'b0;

    // model pins
    chk("pin_kind_ld",   32'(kind(5'b11000)), 32'(K_LD));
    chk("pin_kind_rsv",  32'(kind(5'b01010)), 32'(K_RSV));
    chk("pin_kind_rsv2", 32'(kind(5'b10111)), 32'(K_RSV));
    chk("pin_ifgt_001",  32'(taken(5'd21, 3'b001)), 32'd1);
    chk("pin_ifgt_010",  32'(taken(5'd21, 3'b010)), 32'd0);
    chk("pin_ifnz_001",  32'(taken(5'd18, 3'b001)), 32'd0);

    repeat (3) @(posedge clk);
    idle_step();
    @(negedge clk); #1;
    chk("reset_ready", 32'(bus.instr_ready), 32'd1);
    chk("reset_req",   32'(bus.mem_req), 32'd0);

    txn(5'd1, 2'b01, 8'h10, 0, 0, 0, -1);
    settle_and_look();
    chk("add_rd_sel1", 32'(bus.rd_sel1), 32'h1);
    chk("add_rd_sel2", 32'(bus.rd_sel2), 32'h2);
    txn(5'd9, 2'b11, 8'hA5, 0, 0, 0, -1);
    settle_and_look();
    chk("val_literal", 32'(bus.literal_adr), 32'hA5);
    txn(5'd16, 2'b00, 8'h3F, 0, 0, 0, -1);
    settle_and_look();
    chk("goto_literal", 32'(bus.literal_adr), 32'h3F);
    for (int op = 17; op <= 21; op++)
      for (int i = 0; i < 4; i++) txn(5'(op), 2'($urandom), 8'($urandom), 0, 0, 0, int'(sv[i]));
    txn(5'd24, 2'b10, 8'h20, 3, 0, 0, -1);
    settle_and_look();
    chk("ld_wr_sel", 32'(bus.wr_sel), 32'h2);
    txn(5'd27, 2'b01, 8'h08, 2, 1, 0, -1);
    txn(5'd25, 2'b11, 8'h44, 0, 0, 0, -1);
    settle_and_look();
    chk("st_timeout_err", 32'(bus.mem_err), 32'd1);
    txn(5'd25, 2'b11, 8'h44, T, 0, 0, -1);
    settle_and_look();
    chk("st_late_ack_err", 32'(bus.mem_err), 32'd0);
    txn(5'b01010, 2'b01, 8'h01, 0, 0, 0, -1);
    txn(5'd24, 2'b10, 8'h20, 0, 0, 2, -1);
    settle_and_look();
    chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mid_mem_lit", 32'(bus.literal_adr), 32'd0);

    for (int n = 0; n < 300; n++) begin
      int rst_at;
      rst_at = ($urandom_range(0, 29) == 0) ? $urandom_range(1, T) : 0;
      txn(5'($urandom), 2'($urandom), 8'($urandom), $urandom_range(0, T),
          $urandom_range(0, 2), rst_at, -1);
    end
    idle_step();
    idle_step();
    @(negedge clk); #1;
    exp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
